// File: rtl/chipset_bus_pkg.sv
// Shared types and constants for the XT chipset bus return path.
package chipset_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD,
        DONE
    } bus_state_t;

    localparam int DATA_W_DEFAULT = 8;

    // Index used for "no internal source selected", i.e. the external bus.
    function automatic int src_none(input int num_src);
        return num_src;
    endfunction

endpackage

// File: rtl/bus_src_priority_enc.sv
// Priority encoder for source decode hits: lowest set index wins, NUM_SRC when none are set.
module bus_src_priority_enc #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = $clog2(NUM_SRC) + 1
) (
    input  logic [NUM_SRC-1:0] select,
    output logic [IDX_W-1:0]   index
);

    always_comb begin
        index = IDX_W'(NUM_SRC);
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (select[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_return_controller.sv
// Read-data return path and READY generator with per-source wait states.
// Optional forced completion of stuck accesses is enabled by defining BUS_TIMEOUT_EN.
module bus_return_controller
    import chipset_bus_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int WAIT_W    = 3,
    parameter int TIMEOUT_W = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        io_read_n,
    input  logic                        io_write_n,
    input  logic                        memory_read_n,
    input  logic                        memory_write_n,
    input  logic [NUM_SRC-1:0]          src_select,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    input  logic [NUM_SRC-1:0]          src_ready,
    input  logic [NUM_SRC*WAIT_W-1:0]   src_wait,
    input  logic [DATA_W-1:0]           ext_data_in,
    input  logic                        ext_ready,
    output logic [DATA_W-1:0]           data_bus_out,
    output logic                        data_bus_direction,
    output logic                        processor_ready,
    output logic [$clog2(NUM_SRC):0]    active_src,
    output logic                        bus_timeout
);

    localparam int IDX_W = $clog2(NUM_SRC) + 1;
    localparam logic [IDX_W-1:0] NONE_IDX = IDX_W'(src_none(NUM_SRC));

    bus_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              is_read;
    logic              prev_all_high;

    logic              all_high;
    logic              is_read_now;
    logic              cycle_start;
    logic [IDX_W-1:0]  enc_idx;
    logic [WAIT_W-1:0] sel_wait;
    logic [DATA_W-1:0] cur_data;
    logic              cur_ready;

    assign all_high    = io_read_n & io_write_n & memory_read_n & memory_write_n;
    assign is_read_now = ~io_read_n | ~memory_read_n;
    assign cycle_start = prev_all_high & ~all_high;

    bus_src_priority_enc #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_prio (
        .select (src_select),
        .index  (enc_idx)
    );

    // Wait count of the source about to be latched; the external bus has none.
    always_comb begin
        sel_wait = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (enc_idx == IDX_W'(i)) begin
                sel_wait = src_wait[i*WAIT_W +: WAIT_W];
            end
        end
    end

    always_comb begin
        cur_data  = ext_data_in;
        cur_ready = ext_ready;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (active_src == IDX_W'(i)) begin
                cur_data  = src_data[i*DATA_W +: DATA_W];
                cur_ready = src_ready[i];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = ~TIMEOUT_W'(1);
    logic [TIMEOUT_W-1:0] tmo_cnt;
`else
    assign bus_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            wait_cnt           <= '0;
            is_read            <= 1'b0;
            prev_all_high      <= 1'b1;
            active_src         <= NONE_IDX;
            data_bus_out       <= '0;
            data_bus_direction <= 1'b0;
            processor_ready    <= 1'b1;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt            <= '0;
            bus_timeout        <= 1'b0;
`endif
        end else begin
            prev_all_high <= all_high;
`ifdef BUS_TIMEOUT_EN
            bus_timeout   <= 1'b0;
`endif
            // Strobes released before completion abandon the access without a timeout.
            if ((state == WAIT || state == HOLD) && all_high) begin
                state              <= IDLE;
                wait_cnt           <= '0;
                processor_ready    <= 1'b1;
                data_bus_direction <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cycle_start) begin
                            active_src         <= enc_idx;
                            is_read            <= is_read_now;
                            data_bus_direction <= is_read_now && (enc_idx == NONE_IDX);
                            processor_ready    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
                            tmo_cnt            <= '0;
`endif
                            if (sel_wait != '0) begin
                                wait_cnt <= sel_wait;
                                state    <= WAIT;
                            end else begin
                                state    <= HOLD;
                            end
                        end
                    end
                    WAIT: begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                        if (wait_cnt == WAIT_W'(1)) begin
                            state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (is_read) begin
                            data_bus_out <= cur_data;
                        end
                        if (cur_ready) begin
                            state           <= DONE;
                            processor_ready <= 1'b1;
                        end
`ifdef BUS_TIMEOUT_EN
                        else if (tmo_cnt == TMO_LAST) begin
                            state           <= DONE;
                            processor_ready <= 1'b1;
                            bus_timeout     <= 1'b1;
                            if (is_read) begin
                                data_bus_out <= '1;
                            end
                        end else begin
                            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
                        end
`endif
                    end
                    DONE: begin
                        if (all_high) begin
                            state              <= IDLE;
                            data_bus_direction <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
